// File: rtl/vote_session_controller.sv
// One-ballot voting session sequencer: arm on ballot issue, take exactly one candidate press,
// pulse the vote strobes, then lock out. Define EVM_PRIORITY_RESOLVE_EN to resolve multi-presses by bit0-first priority.
module vote_session_controller #(
    parameter int NUM_CAND       = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCKOUT_CYCLES = 10
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                mode,
    input  logic                ballot_issue,
    input  logic [NUM_CAND-1:0] cand_btn,
    output logic                ballot_ready,
    output logic                busy,
    output logic                valid_vote_casted,
    output logic [NUM_CAND-1:0] vote_inc,
    output logic                invalid_press,
    output logic                timeout,
    output logic [7:0]          ballots_issued
);

    localparam int TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ARMED, CAST, LOCKOUT, REJECT} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_CAND-1:0] btn_prev_q;
    logic [NUM_CAND-1:0] choice_q, choice_d;
    logic [7:0]          count_q, count_d;
    logic                invalid_d, timeout_d;
    logic                ready_q, busy_q, valid_q, invalid_q, timeout_q;
    logic [NUM_CAND-1:0] vote_inc_q;

    logic [NUM_CAND-1:0] press;
    logic                press_multi, press_single;

    // Only rising edges count, so a button already held on arming is ignored.
    assign press        = cand_btn & ~btn_prev_q;
    assign press_multi  = (press & (press - NUM_CAND'(1))) != '0;
    assign press_single = (press != '0) && !press_multi;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        choice_d  = choice_q;
        count_d   = count_q;
        invalid_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ballot_issue && !mode) begin
                    state_d = ARMED;
                    timer_d = '0;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                end
            end
            ARMED: begin
                if (mode) begin
                    state_d = IDLE;
                end else if (press_single) begin
                    state_d  = CAST;
                    choice_d = press;
                end else if (press_multi) begin
`ifdef EVM_PRIORITY_RESOLVE_EN
                    state_d  = CAST;
                    choice_d = press & (~press + NUM_CAND'(1));
`else
                    state_d   = REJECT;
                    invalid_d = 1'b1;
`endif
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CAST: begin
                state_d = LOCKOUT;
                timer_d = '0;
            end
            LOCKOUT: begin
                if (mode) begin
                    state_d = IDLE;
                end else if (timer_q >= LOCKOUT_LAST && cand_btn == '0) begin
                    state_d = IDLE;
                end else if (timer_q < LOCKOUT_LAST) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REJECT: begin
                if (mode) begin
                    state_d = IDLE;
                end else if (cand_btn == '0) begin
                    state_d = ARMED;
                    timer_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            btn_prev_q <= '0;
            choice_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            vote_inc_q <= '0;
            invalid_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            btn_prev_q <= cand_btn;
            choice_q   <= choice_d;
            count_q    <= count_d;
            ready_q    <= (state_d == ARMED);
            busy_q     <= (state_d != IDLE);
            // The vote strobe is registered off CAST itself, so a mode flip cannot cancel it.
            valid_q    <= (state_q == CAST);
            vote_inc_q <= (state_q == CAST) ? choice_q : '0;
            invalid_q  <= invalid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ballot_ready      = ready_q;
    assign busy              = busy_q;
    assign valid_vote_casted = valid_q;
    assign vote_inc          = vote_inc_q;
    assign invalid_press     = invalid_q;
    assign timeout           = timeout_q;
    assign ballots_issued    = count_q;

endmodule

// File: tb/tb_vote_session_controller.sv
// Bench for vote_session_controller: directed scenarios plus random traffic, every cycle
// compared against a session model built from edge timestamps rather than timers.
module tb_vote_session_controller;

    localparam int TO = 20;
    localparam int LO = 10;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode = 1'b0;
    logic       ballot_issue = 1'b0;
    logic [3:0] cand_btn = 4'b0000;
    logic       ballot_ready, busy, valid_vote_casted, invalid_press, timeout;
    logic [3:0] vote_inc;
    logic [7:0] ballots_issued;

    always #5 clock = ~clock;

    vote_session_controller #(
        .NUM_CAND       (4),
        .TIMEOUT_CYCLES (TO),
        .LOCKOUT_CYCLES (LO)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .mode              (mode),
        .ballot_issue      (ballot_issue),
        .cand_btn          (cand_btn),
        .ballot_ready      (ballot_ready),
        .busy              (busy),
        .valid_vote_casted (valid_vote_casted),
        .vote_inc          (vote_inc),
        .invalid_press     (invalid_press),
        .timeout           (timeout),
        .ballots_issued    (ballots_issued)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a session is a phase plus the edge numbers at which it was armed or voted.
    typedef enum {P_NONE, P_WAIT, P_VOTED, P_REJ} phase_t;
    phase_t     ph;
    int         e = 0;
    int         arm_e, cast_e;
    logic [3:0] prev, choice;
    int         issued;
    logic       x_ready, x_busy, x_valid, x_inv, x_to;
    logic [3:0] x_vote;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ph = P_NONE; prev = 4'b0; choice = 4'b0; issued = 0; cast_e = -100; arm_e = 0;
        x_ready = 0; x_busy = 0; x_valid = 0; x_inv = 0; x_to = 0; x_vote = 4'b0;
    endtask

    task automatic model_edge(input logic m, input logic bi, input logic [3:0] b);
        logic [3:0] press;
        int         n;
        press = b & ~prev;
        prev  = b;
        n     = $countones(press);
        e++;
        x_inv = 0; x_to = 0;
        x_valid = (e == cast_e + 1);
        x_vote  = x_valid ? choice : 4'b0;
        case (ph)
            P_NONE: if (bi && !m) begin
                ph = P_WAIT; arm_e = e;
                if (issued < 255) issued++;
            end
            P_WAIT: begin
                if (m) ph = P_NONE;
                else if (n == 1) begin ph = P_VOTED; cast_e = e; choice = press; end
                else if (n >= 2) begin
`ifdef EVM_PRIORITY_RESOLVE_EN
                    ph = P_VOTED; cast_e = e; choice = 4'b0;
                    for (int i = 3; i >= 0; i--) if (press[i]) choice = 4'b0001 << i;
`else
                    ph = P_REJ; x_inv = 1;
`endif
                end
                else if (e - arm_e == TO) begin ph = P_NONE; x_to = 1; end
            end
            P_VOTED: if (e >= cast_e + 2) begin
                if (m) ph = P_NONE;
                else if ((e - cast_e - 2) >= LO - 1 && b == 4'b0) ph = P_NONE;
            end
            P_REJ: begin
                if (m) ph = P_NONE;
                else if (b == 4'b0) begin ph = P_WAIT; arm_e = e; end
            end
            default: ph = P_NONE;
        endcase
        x_ready = (ph == P_WAIT);
        x_busy  = (ph != P_NONE);
    endtask

    task automatic compare_all();
        check("ballot_ready",      {7'd0, ballot_ready},      {7'd0, x_ready});
        check("busy",              {7'd0, busy},              {7'd0, x_busy});
        check("valid_vote_casted", {7'd0, valid_vote_casted}, {7'd0, x_valid});
        check("vote_inc",          {4'd0, vote_inc},          {4'd0, x_vote});
        check("invalid_press",     {7'd0, invalid_press},     {7'd0, x_inv});
        check("timeout",           {7'd0, timeout},           {7'd0, x_to});
        check("ballots_issued",    ballots_issued,            8'(issued));
    endtask

    task automatic tick(input logic m, input logic bi, input logic [3:0] b);
        mode = m; ballot_issue = bi; cand_btn = b;
        @(posedge clock);
        model_edge(m, bi, b);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, b);
    endtask

    int         votes_seen;
    logic       rm;
    logic [3:0] rb;

    initial begin
        model_reset();
        #2 compare_all();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2, 4'b0000);

        // Single vote for candidate 3 five cycles after arming; count the strobes.
        tick(1'b0, 1'b1, 4'b0000);
        idle(4, 4'b0000);
        votes_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 4'b0100);
            votes_seen += int'(valid_vote_casted);
        end
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b0, 4'b0000);
            votes_seen += int'(valid_vote_casted);
        end
        check("single_vote_count", 8'(votes_seen), 8'd1);
        check("ballots_after_one", ballots_issued, 8'd1);

        // Multi-press, release, then a clean press of candidate 4.
        tick(1'b0, 1'b1, 4'b0000);
        idle(2, 4'b0011);
        idle(2, 4'b0000);
        idle(3, 4'b1000);
        idle(15, 4'b0000);

        // Abandoned ballot times out; a later press yields nothing.
        tick(1'b0, 1'b1, 4'b0000);
        idle(TO + 3, 4'b0000);
        idle(2, 4'b0010);
        idle(4, 4'b0000);

        // Button held across arming never counts; a fresh press does.
        idle(2, 4'b0001);
        tick(1'b0, 1'b1, 4'b0001);
        idle(10, 4'b0001);
        idle(2, 4'b0000);
        idle(2, 4'b0001);
        idle(15, 4'b0000);

        // Button held 50 cycles after the cast keeps LOCKOUT alive.
        tick(1'b0, 1'b1, 4'b0000);
        idle(1, 4'b0000);
        idle(50, 4'b0010);
        check("busy_while_held", {7'd0, busy}, 8'd1);
        idle(15, 4'b0000);

        // Asynchronous reset while armed clears every output at once.
        tick(1'b0, 1'b1, 4'b0000);
        idle(3, 4'b0000);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2, 4'b0000);

        // Ballot issue in result mode is ignored.
        tick(1'b1, 1'b1, 4'b0000);
        tick(1'b1, 1'b0, 4'b0000);
        check("result_mode_ignored", ballots_issued, 8'd0);

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b1, 4'b0000);
            tick(1'b1, 1'b0, 4'b0000);
        end
        check("ballots_saturate", ballots_issued, 8'd255);

        // Random traffic against the model.
        rm = 1'b0;
        rb = 4'b0000;
        for (int i = 0; i < 4000; i++) begin
            if (rm) rm = ($urandom_range(0, 4) != 0);
            else    rm = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    rb = 4'b0000;
                    2:       rb = 4'b0001 << $urandom_range(0, 3);
                    default: rb = 4'($urandom_range(0, 15));
                endcase
            end
            tick(rm, ($urandom_range(0, 7) == 0), rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
